countdown_timer_bcd: RTL and testbench

//   Loadable mm:ss BCD countdown timer, the decrementing counterpart of the team's clock-enabled up-counter.

---
 rtl/countdown_pkg.sv | 15 +
 rtl/bcd_down_digit.sv | 35 +++
 rtl/countdown_timer_bcd.sv | 127 ++++++++++++
 tb/tb_countdown_timer_bcd.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the mm:ss BCD countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: wraps 0 -> MAX with a borrow, clamps loads to MAX.
module bcd_down_digit
    import countdown_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ld,
    input  bcd_t d,
    output bcd_t q,
    output logic borrow_out
);

    localparam bcd_t MAX_BCD = bcd_t'(MAX);

    bcd_t r_q;
    bcd_t w_d_clamped;

    assign w_d_clamped = (d > MAX_BCD) ? MAX_BCD : d;
    assign borrow_out  = en && (r_q == 4'd0);
    assign q           = r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= 4'd0;
        end else if (ld) begin
            r_q <= w_d_clamped;
        end else if (en) begin
            r_q <= (r_q == 4'd0) ? MAX_BCD : (r_q - 4'd1);
        end
    end

endmodule

// File: rtl/countdown_timer_bcd.sv
// Loadable mm:ss BCD countdown timer with start/pause/done control, ticked by a clock enable.
module countdown_timer_bcd
    import countdown_pkg::*;
#(
    parameter int MAX_MIN_TENS = 5,
    parameter int MAX_SEC_TENS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        ld,
    input  logic [15:0] d,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] q,
    output logic        running,
    output logic        expired,
    output logic        done
);

    state_t      r_state;
    logic        r_running;
    logic        r_expired;
    logic        r_done;

    logic [15:0] w_q;
    logic [4:0]  w_en;
    logic [3:0]  w_borrow;
    logic        w_q_zero;
    logic        w_q_one;
    logic        w_dec;
    logic        w_start_only;
    logic        w_expire_tick;

    assign w_q_zero     = (w_q == 16'h0000);
    assign w_q_one      = (w_q == 16'h0001);
    assign w_start_only = start && !stop;

    // Never decrement 00:00, so the chain cannot underflow.
    assign w_dec   = (r_state == ST_RUN) && !ld && !stop && ce && !w_q_zero;
    assign w_en[0] = w_dec;

    // Digit order: s1, s10, m1, m10 (least significant first).
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        localparam int LMAX = (gi % 2 == 0) ? int'(BCD_NINE)
                            : ((gi == 1) ? MAX_SEC_TENS : MAX_MIN_TENS);

        bcd_down_digit #(
            .MAX(LMAX)
        ) u_digit (
            .clk        (clk),
            .rst        (rst),
            .en         (w_en[gi]),
            .ld         (ld),
            .d          (d[gi*4 +: 4]),
            .q          (w_q[gi*4 +: 4]),
            .borrow_out (w_borrow[gi])
        );

        assign w_en[gi+1] = w_en[gi] & w_borrow[gi];
    end

    // A borrow out of the top digit would be a wrap past 00:00; treat it as expiry as well.
    assign w_expire_tick = w_dec && (w_q_one || w_en[4]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (ld) begin
                r_state   <= ST_IDLE;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_only) begin
                            if (w_q_zero) begin
                                r_state   <= ST_DONE;
                                r_expired <= 1'b1;
                                r_done    <= 1'b1;
                            end else begin
                                r_state   <= ST_RUN;
                                r_running <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                        end else if (w_expire_tick) begin
                            r_state   <= ST_DONE;
                            r_running <= 1'b0;
                            r_expired <= 1'b1;
                            r_done    <= 1'b1;
                        end
                    end
                    ST_PAUSE: begin
                        if (w_start_only) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_DONE;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                        r_expired <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign q       = w_q;
    assign running = r_running;
    assign expired = r_expired;
    assign done    = r_done;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Randomized and directed check of countdown_timer_bcd against a seconds-based reference model.
module tb_countdown_timer_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        ld = 1'b0;
    logic [15:0] d = 16'h0000;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] q;
    logic        running;
    logic        expired;
    logic        done;

    countdown_timer_bcd #(
        .MAX_MIN_TENS(5),
        .MAX_SEC_TENS(5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .ld      (ld),
        .d       (d),
        .start   (start),
        .stop    (stop),
        .q       (q),
        .running (running),
        .expired (expired),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: remaining time as a plain number of seconds plus a mode.
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    int m_secs = 0;
    int m_mode = M_IDLE;
    bit m_done = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int load_secs(input logic [15:0] v);
        int mm;
        int ss;
        mm = min_int(int'(v[15:12]), 5) * 10 + min_int(int'(v[11:8]), 9);
        ss = min_int(int'(v[7:4]), 5) * 10 + min_int(int'(v[3:0]), 9);
        return mm * 60 + ss;
    endfunction

    function automatic logic [15:0] to_bcd(input int secs);
        int mm;
        int ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic void model_reset();
        m_secs = 0;
        m_mode = M_IDLE;
        m_done = 1'b0;
    endfunction

    function automatic void model_tick(input bit i_ld, input logic [15:0] i_d,
                                       input bit i_start, input bit i_stop, input bit i_ce);
        m_done = 1'b0;
        if (i_ld) begin
            m_secs = load_secs(i_d);
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (i_start && !i_stop) begin
                    if (m_secs == 0) begin
                        m_mode = M_DONE;
                        m_done = 1'b1;
                    end else begin
                        m_mode = M_RUN;
                    end
                end
                M_RUN: if (i_stop) begin
                    m_mode = M_PAUSE;
                end else if (i_ce) begin
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin
                        m_mode = M_DONE;
                        m_done = 1'b1;
                    end
                end
                M_PAUSE: if (i_start && !i_stop) m_mode = M_RUN;
                default: ;
            endcase
        end
    endfunction

    task automatic check_all(input string ctx);
        check({ctx, ".q"}, q, to_bcd(m_secs));
        check({ctx, ".running"}, {15'd0, running}, {15'd0, (m_mode == M_RUN)});
        check({ctx, ".expired"}, {15'd0, expired}, {15'd0, (m_mode == M_DONE)});
        check({ctx, ".done"}, {15'd0, done}, {15'd0, m_done});
    endtask

    // One transaction: drive inputs, clock once, update model, check 1 time unit later.
    task automatic step(input string ctx, input bit i_ld, input logic [15:0] i_d,
                        input bit i_start, input bit i_stop, input bit i_ce);
        ld = i_ld;
        d = i_d;
        start = i_start;
        stop = i_stop;
        ce = i_ce;
        @(posedge clk);
        if (rst) model_tick(i_ld, i_d, i_start, i_stop, i_ce);
        else     model_reset();
        #1;
        check_all(ctx);
        $display("%-10s ld=%0b d=%h st=%0b sp=%0b ce=%0b -> q=%h run=%0b exp=%0b done=%0b",
                 ctx, i_ld, i_d, i_start, i_stop, i_ce, q, running, expired, done);
    endtask

    initial begin
        logic [15:0] rd;

        // Held in reset while inputs toggle.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("reset", 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        rst = 1'b1;

        // Borrow through all digits.
        step("borrow", 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        step("borrow", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step("borrow", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("borrow.lit1", q, 16'h0959);
        step("borrow", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("borrow.lit2", q, 16'h0958);

        // Expiry and inertness in DONE.
        step("expiry", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        step("expiry", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step("expiry", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        step("expiry", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("expiry.done", {15'd0, done}, 16'd1);
        for (int i = 0; i < 4; i++) step("in_done", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        check("expiry.hold", {expired, done, q[13:0]}, 16'h8000);

        // Pause and start/stop priority.
        step("pause", 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
        step("pause", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("pause", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("pause.lit27", q, 16'h0027);
        step("pause", 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step("paused", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("pause.held", q, 16'h0027);
        step("resume", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step("resume", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("pause.lit26", q, 16'h0026);

        // Clamp, zero start, load out of DONE, load beats ce.
        step("clamp", 1'b1, 16'hFAFA, 1'b0, 1'b0, 1'b1);
        check("clamp.lit", q, 16'h5959);
        step("zero", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        step("zero", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step("zero", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        step("ld_done", 1'b1, 16'h0310, 1'b0, 1'b0, 1'b1);
        step("ld_ce", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step("ld_ce", 1'b1, 16'h0200, 1'b1, 1'b0, 1'b1);

        // Async reset between edges mid-run.
        step("arst", 1'b1, 16'h0105, 1'b0, 1'b0, 1'b0);
        step("arst", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step("arst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        step("arst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("arst_now");
        step("arst_hold", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;

        // Randomized traffic, biased towards short counts so expiry is exercised.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rd = {12'h000, 4'($urandom_range(0, 5))};
                1:       rd = {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
                default: rd = 16'($urandom);
            endcase
            step("rand", ($urandom_range(0, 11) == 0), rd, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
